// File: rtl/iadc_pkg.sv
// Shared types and default parameters for the incremental-ADC conversion sequencer.
package iadc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    CONV = 3'd2,
    WAIT = 3'd3,
    CAP  = 3'd4
  } state_e;

  localparam int OSR_DEF     = 512;
  localparam int DATA_W_DEF  = 12;
  localparam int RST_CYC_DEF = 2;
  localparam int DEC_LAT_DEF = 1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iadc_conv_ctrl_if.sv
// Control, datapath and result-handshake signals between the sequencer and its neighbours.
interface iadc_conv_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              start;
  logic              cont;
  logic              abort;
  logic [DATA_W-1:0] dec_data;
  logic              mod_rst_n;
  logic              dec_clr;
  logic              sample_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              overrun;

  modport master (
    input  start, cont, abort, dec_data, dout_ready,
    output mod_rst_n, dec_clr, sample_en, dout, dout_valid, busy, overrun
  );

  modport slave (
    output start, cont, abort, dec_data, dout_ready,
    input  mod_rst_n, dec_clr, sample_en, dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/iadc_out_reg.sv
// Result holding register with valid/ready handshake; a newer capture always overwrites.
// IADC_CTRL_OVERRUN_EN adds a sticky overrun flag for overwrites of unread results.
module iadc_out_reg
  import iadc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] dout_d, dout_q;
  logic              dout_valid_d, dout_valid_q;

  // A capture in the same cycle as a transfer wins, so valid stays high.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    if (cap) begin
      dout_d       = cap_data;
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef IADC_CTRL_OVERRUN_EN
  logic overrun_d, overrun_q;

  always_comb begin
    overrun_d = overrun_q | (cap & dout_valid_q & ~dout_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: rtl/iadc_conv_ctrl.sv
// Incremental-ADC conversion sequencer: reset, OSR samples, decimator latency, capture.
// Optional sticky overrun flag enabled with IADC_CTRL_OVERRUN_EN.
module iadc_conv_ctrl
  import iadc_pkg::*;
#(
  parameter int OSR     = OSR_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int DEC_LAT = DEC_LAT_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  iadc_conv_ctrl_if.master   bus
);

  localparam int CNT_W = $clog2(OSR);
  localparam int PH_W  = cnt_w((RST_CYC > DEC_LAT) ? RST_CYC : DEC_LAT);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(OSR - 1);
  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0]  WAIT_LAST = PH_W'((DEC_LAT > 0) ? DEC_LAT - 1 : 0);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] conv_cnt_d, conv_cnt_q;
  logic [PH_W-1:0]  ph_cnt_d, ph_cnt_q;
  logic             mod_rst_n_d, mod_rst_n_q;
  logic             dec_clr_d, dec_clr_q;
  logic             sample_en_d, sample_en_q;
  logic             busy_d, busy_q;
  logic             cap;

  // RST and WAIT share one phase counter; they are never active together.
  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    case (state_q)
      IDLE: begin
        conv_cnt_d = '0;
        ph_cnt_d   = '0;
        if (bus.start && !bus.abort) state_d = RST;
      end
      RST: begin
        if (ph_cnt_q == RST_LAST) begin
          ph_cnt_d = '0;
          state_d  = CONV;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      CONV: begin
        if (conv_cnt_q == CONV_LAST) begin
          conv_cnt_d = '0;
          state_d    = (DEC_LAT == 0) ? CAP : WAIT;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (ph_cnt_q == WAIT_LAST) begin
          ph_cnt_d = '0;
          state_d  = CAP;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      CAP:     state_d = bus.cont ? RST : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      conv_cnt_d = '0;
      ph_cnt_d   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    mod_rst_n_d = (state_d == CONV) || (state_d == WAIT) || (state_d == CAP);
    dec_clr_d   = !mod_rst_n_d;
    sample_en_d = (state_d == CONV);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      conv_cnt_q  <= '0;
      ph_cnt_q    <= '0;
      mod_rst_n_q <= 1'b0;
      dec_clr_q   <= 1'b1;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      mod_rst_n_q <= mod_rst_n_d;
      dec_clr_q   <= dec_clr_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
    end
  end

  // An abort arriving during CAP discards the result.
  assign cap = (state_q == CAP) && !bus.abort;

  iadc_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap        (cap),
    .cap_data   (bus.dec_data),
    .dout_ready (bus.dout_ready),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .overrun    (bus.overrun)
  );

  assign bus.mod_rst_n = mod_rst_n_q;
  assign bus.dec_clr   = dec_clr_q;
  assign bus.sample_en = sample_en_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
// Directed self-checking bench: short-OSR instance for sequencing/handshake, full-OSR instance for continuous mode.
module tb_iadc_conv_ctrl;

  localparam int DW = 12;

`ifdef IADC_CTRL_OVERRUN_EN
  localparam int OVR_EXP = 1;
`else
  localparam int OVR_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  iadc_conv_ctrl_if #(.DATA_W(DW)) ifa ();
  iadc_conv_ctrl_if #(.DATA_W(DW)) ifb ();

  iadc_conv_ctrl #(.OSR(8), .RST_CYC(2), .DEC_LAT(1), .DATA_W(DW)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  iadc_conv_ctrl #(.OSR(512), .RST_CYC(2), .DEC_LAT(0), .DATA_W(DW)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int errors = 0;
  int checks = 0;
  int nse;
  int nres;
  int run;
  int last_t;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_mod_rst_n"},  32'(ifa.mod_rst_n),  0);
    chk({tag, "_dec_clr"},    32'(ifa.dec_clr),    1);
    chk({tag, "_sample_en"},  32'(ifa.sample_en),  0);
    chk({tag, "_busy"},       32'(ifa.busy),       0);
    chk({tag, "_dout"},       32'(ifa.dout),       0);
    chk({tag, "_dout_valid"}, 32'(ifa.dout_valid), 0);
    chk({tag, "_overrun"},    32'(ifa.overrun),    0);
  endtask

  initial begin
    rst_n          = 1'b0;
    ifa.start      = 1'b0;
    ifa.cont       = 1'b0;
    ifa.abort      = 1'b0;
    ifa.dec_data   = '0;
    ifa.dout_ready = 1'b0;
    ifb.start      = 1'b0;
    ifb.cont       = 1'b0;
    ifb.abort      = 1'b0;
    ifb.dec_data   = '0;
    ifb.dout_ready = 1'b0;
    tick(2);
    chk_reset_a("rst");
    rst_n = 1'b1;
    tick(1);

    // Single shot: start accepted at edge N
    ifa.dec_data   = 12'h0A5;
    ifa.dout_ready = 1'b1;
    start_a();
    chk("t1_busy", 32'(ifa.busy), 1);
    chk("t1_mod_rst_held", 32'(ifa.mod_rst_n), 0);
    nse = 32'(ifa.sample_en);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      nse += 32'(ifa.sample_en);
      if (k == 2)  chk("t1_mod_rst_release", 32'(ifa.mod_rst_n), 1);
      if (k == 11) chk("t1_valid_early", 32'(ifa.dout_valid), 0);
    end
    chk("t1_sample_cycles", 32'(nse), 8);
    tick(1);
    chk("t1_valid", 32'(ifa.dout_valid), 1);
    chk("t1_dout", 32'(ifa.dout), 32'h0A5);
    chk("t1_idle", 32'(ifa.busy), 0);
    tick(1);
    chk("t1_accept", 32'(ifa.dout_valid), 0);

    // Backpressure: two results without a transfer
    ifa.dout_ready = 1'b0;
    ifa.dec_data   = 12'h111;
    start_a();
    tick(12);
    chk("t2_dout1", 32'(ifa.dout), 32'h111);
    chk("t2_valid1", 32'(ifa.dout_valid), 1);
    chk("t2_ovr_none", 32'(ifa.overrun), 0);
    ifa.dec_data = 12'h222;
    start_a();
    tick(12);
    chk("t2_dout2", 32'(ifa.dout), 32'h222);
    chk("t2_valid2", 32'(ifa.dout_valid), 1);
    chk("t2_ovr", 32'(ifa.overrun), 32'(OVR_EXP));
    ifa.dout_ready = 1'b1;
    tick(1);
    chk("t2_accept", 32'(ifa.dout_valid), 0);
    chk("t2_ovr_sticky", 32'(ifa.overrun), 32'(OVR_EXP));

    // Abort at CONV count 3
    ifa.dec_data = 12'h777;
    start_a();
    tick(5);
    chk("t3_in_conv", 32'(ifa.sample_en), 1);
    ifa.abort = 1'b1;
    tick(1);
    ifa.abort = 1'b0;
    chk("t3_abort_busy", 32'(ifa.busy), 0);
    chk("t3_abort_sample", 32'(ifa.sample_en), 0);
    chk("t3_abort_mod_rst", 32'(ifa.mod_rst_n), 0);
    tick(12);
    chk("t3_no_valid", 32'(ifa.dout_valid), 0);
    chk("t3_dout_kept", 32'(ifa.dout), 32'h222);
    ifa.dec_data = 12'h3C3;
    start_a();
    tick(12);
    chk("t3_restart_valid", 32'(ifa.dout_valid), 1);
    chk("t3_restart_dout", 32'(ifa.dout), 32'h3C3);

    // abort beats start in IDLE; start pulse while busy is ignored
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    chk("t4_abort_over_start", 32'(ifa.busy), 0);
    ifa.dec_data = 12'h5A5;
    start_a();
    tick(3);
    ifa.start = 1'b1;
    tick(1);
    ifa.start = 1'b0;
    tick(8);
    chk("t4_dout", 32'(ifa.dout), 32'h5A5);
    chk("t4_valid", 32'(ifa.dout_valid), 1);
    chk("t4_idle", 32'(ifa.busy), 0);
    tick(14);
    chk("t4_no_second", 32'(ifa.busy), 0);
    chk("t4_no_second_valid", 32'(ifa.dout_valid), 0);

    // rst_n low while in WAIT
    ifa.dec_data = 12'h6B6;
    start_a();
    tick(10);
    chk("t5_in_wait_busy", 32'(ifa.busy), 1);
    chk("t5_in_wait_sample", 32'(ifa.sample_en), 0);
    rst_n = 1'b0;
    tick(1);
    chk_reset_a("t5");
    rst_n = 1'b1;
    tick(15);
    chk("t5_no_result", 32'(ifa.dout_valid), 0);
    chk("t5_dout_zero", 32'(ifa.dout), 0);

    // Continuous mode on the full-OSR instance, ramp on dec_data
    ifb.cont       = 1'b1;
    ifb.dout_ready = 1'b1;
    ifb.dec_data   = 12'h100;
    ifb.start      = 1'b1;
    tick(1);
    ifb.start = 1'b0;
    nres   = 0;
    run    = 0;
    last_t = 0;
    for (int t = 0; t < 2200; t++) begin
      if (t != 0) tick(1);
      if (ifb.busy && !ifb.mod_rst_n) begin
        run++;
      end else if (run != 0) begin
        chk("t6_rst_len", 32'(run), 2);
        run = 0;
      end
      if (ifb.dout_valid) begin
        nres++;
        chk("t6_dout_ramp", 32'(ifb.dout), 32'(ifb.dec_data));
        chk("t6_spacing", 32'(t - last_t), 515);
        last_t = t;
      end
      if (t == 1200) ifb.cont = 1'b0;
      ifb.dec_data = ifb.dec_data + 1'b1;
    end
    chk("t6_results", 32'(nres), 3);
    chk("t6_idle", 32'(ifb.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
